mio_responder: RTL

Memory/IO responder on the CPU side of the memory bus. It accepts the multi-cycle datapath's word read and write requests and returns read data with an `MIO_ready` handshake. It decodes the address into a 1K-word data RAM, a GPIO register pair and a free-running counter. Accesses complete after a programmable number of wait states, and the CPU stalls its PC update on `MIO_ready`.

---
 rtl/mio_responder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mio_responder.sv
`default_nettype none
// ============================================================================
// Module   : mio_responder
// Purpose  : CPU-side memory/IO responder with 1K-word RAM, GPIO, counter and
//            programmable wait states; MIO_ready stalls the CPU PC update.
// Revision : 1.0  initial release
// ============================================================================
module mio_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int RAM_WORDS   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_r,
  input  logic        mem_w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [15:0] sw,
  output logic [31:0] rdata,
  output logic        MIO_ready,
  output logic [15:0] led,
  output logic        busy
);

  localparam int          c_aw        = $clog2(RAM_WORDS);
  localparam logic [3:0]  c_wait_init = 4'(WAIT_CYCLES);
  localparam logic [29:0] c_gpio_word = 30'h3C00_0000;
  localparam logic [29:0] c_cnt_word  = 30'h3C00_0001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        wcnt_q,  wcnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       cnt_q,   cnt_d;
  logic [15:0]       led_q,   led_d;
  logic [31:0]       mem [RAM_WORDS];

  logic              w_req;
  logic              w_commit;
  logic              w_is_ram;
  logic              w_is_gpio;
  logic              w_is_cnt;
  logic [c_aw-1:0]   w_ram_idx;
  logic [31:0]       w_rd_src;
  logic              w_unused_addr;

  assign w_req         = mem_r | mem_w;
  assign w_commit      = (state_q == ST_WAIT) && (wcnt_q == 4'd0);
  assign w_is_ram      = (addr[31:28] == 4'h0);
  assign w_is_gpio     = (addr[31:2] == c_gpio_word);
  assign w_is_cnt      = (addr[31:2] == c_cnt_word);
  assign w_ram_idx     = addr[c_aw+1:2];
  assign w_unused_addr = ^addr[1:0];

  always_comb begin
    w_rd_src = 32'h0;
    if (w_is_ram)       w_rd_src = mem[w_ram_idx];
    else if (w_is_gpio) w_rd_src = {16'h0, sw};
    else if (w_is_cnt)  w_rd_src = cnt_q;
  end

  // Read source is sampled before the write lands, so a combined
  // read+write returns the pre-write value.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rdata_d = rdata_q;
    led_d   = led_q;
    cnt_d   = cnt_q + 32'd1;
    case (state_q)
      ST_IDLE: begin
        if (w_req) begin
          state_d = ST_WAIT;
          wcnt_d  = c_wait_init;
        end
      end
      ST_WAIT: begin
        if (w_commit) state_d = ST_DONE;
        else          wcnt_d  = wcnt_q - 4'd1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (w_commit) begin
      rdata_d = w_rd_src;
      if (mem_w && w_is_gpio) led_d = wdata[15:0];
      if (mem_w && w_is_cnt)  cnt_d = wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wcnt_q  <= 4'd0;
      rdata_q <= 32'h0;
      led_q   <= 16'h0;
      cnt_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rdata_q <= rdata_d;
      led_q   <= led_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit && mem_w && w_is_ram) mem[w_ram_idx] <= wdata;
  end

  assign MIO_ready = ((state_q == ST_IDLE) && !w_req) || (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign rdata     = rdata_q;
  assign led       = led_q;

endmodule
`default_nettype wire
